// File: rtl/bk_sector_seq.sv
// Save-state sector sequencer: walks one slot of 2^SECT_BITS sectors between the
// state buffer and the backup image over the hps_io sd_lba/sd_rd/sd_wr/sd_ack handshake.
module bk_sector_seq #(
    parameter int SLOT_BITS = 2,
    parameter int SECT_BITS = 6,
    parameter int TIMEOUT   = 50000000
) (
    input  logic                 clk_sys,
    input  logic                 RESET_n,
    input  logic                 downloading,
    input  logic                 img_mounted,
    input  logic                 img_size_nz,
    input  logic                 img_readonly,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 sd_ack,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [SECT_BITS-1:0] sect_idx,
    output logic                 bk_ena,
    output logic                 busy,
    output logic                 loading,
    output logic                 done,
    output logic                 err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SLOT_BITS-1:0]   slot_q, slot_d;
    logic [SECT_BITS-1:0]   sect_q, sect_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   busy_q, busy_d;
    logic                   load_q, load_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   ena_q, ena_d;
    logic                   dl_q, ql_q, qs_q, ack_q;

    logic q_load, q_save, start_load, start_save, ack_rise, ack_fall;

    assign q_load     = load_req & ena_q;
    assign q_save     = save_req & ena_q;
    assign start_load = q_load & ~ql_q;
    assign start_save = q_save & ~qs_q;
    assign ack_rise   = sd_ack & ~ack_q;
    assign ack_fall   = ~sd_ack & ack_q;

    always_comb begin
        ena_d = ena_q;
        // Qualification wins over the download edge when both land together.
        if (downloading & img_mounted & img_size_nz & ~img_readonly)
            ena_d = 1'b1;
        else if (downloading & ~dl_q)
            ena_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        sect_d  = sect_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        load_d  = load_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_load | start_save) begin
                    state_d = REQ;
                    slot_d  = slot;
                    sect_d  = '0;
                    load_d  = start_load;
                    rd_d    = start_load;
                    wr_d    = ~start_load;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    load_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            XFER: begin
                if (ack_fall) begin
                    if (&sect_q) begin
                        busy_d  = 1'b0;
                        load_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Sector field wraps on its own; the slot field is never touched.
                        sect_d  = sect_q + SECT_BITS'(1);
                        rd_d    = load_q;
                        wr_d    = ~load_q;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            sect_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ena_q   <= 1'b0;
            dl_q    <= 1'b0;
            ql_q    <= 1'b0;
            qs_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            sect_q  <= sect_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ena_q   <= ena_d;
            dl_q    <= downloading;
            ql_q    <= q_load;
            qs_q    <= q_save;
            ack_q   <= sd_ack;
        end
    end

    assign sd_lba   = {{(32 - SLOT_BITS - SECT_BITS){1'b0}}, slot_q, sect_q};
    assign sect_idx = sect_q;
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;
    assign bk_ena   = ena_q;
    assign busy     = busy_q;
    assign loading  = load_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bk_sector_seq.sv
// Bench for bk_sector_seq: directed scenarios plus random traffic, checked every
// cycle against an operation-level model and pinned by literal expectations.
`timescale 1ns/1ps
module tb_bk_sector_seq;

    localparam int SLOT_BITS = 2;
    localparam int SECT_BITS = 6;
    localparam int TIMEOUT   = 16;
    localparam int NSECT     = 1 << SECT_BITS;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic                 RESET_n = 1'b0;
    logic                 downloading = 1'b0, img_mounted = 1'b0, img_size_nz = 1'b0, img_readonly = 1'b0;
    logic                 load_req = 1'b0, save_req = 1'b0, sd_ack = 1'b0;
    logic [SLOT_BITS-1:0] slot = '0;
    logic [31:0]          sd_lba;
    logic                 sd_rd, sd_wr, bk_ena, busy, loading, done, err;
    logic [SECT_BITS-1:0] sect_idx;

    bk_sector_seq #(.SLOT_BITS(SLOT_BITS), .SECT_BITS(SECT_BITS), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .RESET_n(RESET_n), .downloading(downloading), .img_mounted(img_mounted),
        .img_size_nz(img_size_nz), .img_readonly(img_readonly), .load_req(load_req), .save_req(save_req),
        .slot(slot), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sect_idx(sect_idx),
        .bk_ena(bk_ena), .busy(busy), .loading(loading), .done(done), .err(err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- sd_ack responder (hps_io stand-in) ----------------
    // mode 0: never acks; 1: short random delays; 2: occasionally too slow; 3: delay 1, ack 3 cycles
    int ack_mode = 1;
    int rsp_state = 0;
    int rsp_cnt = 0;
    always @(posedge clk_sys) begin
        #2;
        if (!RESET_n) begin
            sd_ack = 1'b0;
            rsp_state = 0;
        end else begin
            case (rsp_state)
                0: if ((sd_rd | sd_wr) && ack_mode != 0) begin
                    if (ack_mode == 3)      rsp_cnt = 0;
                    else if (ack_mode == 2) rsp_cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 24) : $urandom_range(0, 3);
                    else                    rsp_cnt = $urandom_range(0, 3);
                    rsp_state = 1;
                end
                1: if (!(sd_rd | sd_wr)) rsp_state = 0;
                   else if (rsp_cnt == 0) begin
                       sd_ack = 1'b1;
                       rsp_cnt = (ack_mode == 3) ? 2 : $urandom_range(0, 2);
                       rsp_state = 2;
                   end else rsp_cnt--;
                2: if (rsp_cnt == 0) begin
                       sd_ack = 1'b0;
                       rsp_state = 0;
                   end else rsp_cnt--;
                default: rsp_state = 0;
            endcase
        end
    end

    // ---------------- behavioural model ----------------
    // An operation is: a base sector (slot * NSECT), a count of sectors finished,
    // whether the current sector is still waiting for its ack, and cycles spent waiting.
    bit m_ena = 0, m_dl = 0, m_pl = 0, m_ps = 0, m_ack = 0;
    bit m_active = 0, m_is_load = 0, m_waiting = 0, m_done = 0, m_err = 0;
    int m_base = 0, m_sectors = 0, m_wait = 0;

    always @(posedge clk_sys) begin
        bit ql, qs, sl, ss, rise, fall;
        if (!RESET_n) begin
            m_ena = 0; m_dl = 0; m_pl = 0; m_ps = 0; m_ack = 0;
            m_active = 0; m_is_load = 0; m_waiting = 0; m_done = 0; m_err = 0;
            m_base = 0; m_sectors = 0; m_wait = 0;
        end else begin
            m_done = 0;
            m_err = 0;
            ql = load_req & m_ena;
            qs = save_req & m_ena;
            sl = ql & !m_pl;
            ss = qs & !m_ps;
            rise = sd_ack & !m_ack;
            fall = !sd_ack & m_ack;
            if (!m_active) begin
                if (sl || ss) begin
                    m_active = 1; m_is_load = sl; m_base = int'(slot) * NSECT;
                    m_sectors = 0; m_waiting = 1; m_wait = 0;
                end
            end else if (m_waiting) begin
                if (rise) m_waiting = 0;
                else if (m_wait == TIMEOUT - 1) begin m_active = 0; m_err = 1; end
                else m_wait++;
            end else if (fall) begin
                if (m_sectors == NSECT - 1) begin m_active = 0; m_done = 1; end
                else begin m_sectors++; m_waiting = 1; m_wait = 0; end
            end
            m_pl = ql;
            m_ps = qs;
            m_ack = sd_ack;
            if (downloading && img_mounted && img_size_nz && !img_readonly) m_ena = 1;
            else if (downloading && !m_dl) m_ena = 0;
            m_dl = downloading;
        end
    end

    // ---------------- per-cycle compare + transaction monitor ----------------
    int cyc = 0;
    bit prev_req = 0, prev_busy = 0, prev_ena = 0;
    int req_rises = 0, wr_rises = 0, rd_rises = 0, wr_cycles = 0, rd_cycles = 0, load_cycles = 0;
    int done_cnt = 0, err_cnt = 0, starts = 0, order_bad = 0, first_lba = 0, last_lba = 0;
    int ena_rise_cyc = 0, busy_rise_cyc = 0;

    always @(negedge clk_sys) begin
        logic [6:0]  exp_flags;
        logic [31:0] exp_lba;
        exp_flags = {m_ena, m_active, m_active & m_is_load, m_active & m_waiting & m_is_load,
                     m_active & m_waiting & !m_is_load, m_done, m_err};
        exp_lba = 32'(m_base + m_sectors);
        tests++;
        if ({bk_ena, busy, loading, sd_rd, sd_wr, done, err} !== exp_flags ||
            sd_lba !== exp_lba || sect_idx !== exp_lba[SECT_BITS-1:0]) begin
            fails++;
            $display("FAIL cycle_compare cyc=%0d: ena/busy/load/rd/wr/done/err=%b lba=%h idx=%h, expected %b lba=%h",
                     cyc, {bk_ena, busy, loading, sd_rd, sd_wr, done, err}, sd_lba, sect_idx, exp_flags, exp_lba);
        end

        cyc++;
        if ((sd_rd | sd_wr) && !prev_req) begin
            if (req_rises == 0) first_lba = int'(sd_lba);
            else if (int'(sd_lba) != last_lba + 1) order_bad++;
            last_lba = int'(sd_lba);
            req_rises++;
            if (sd_wr) wr_rises++;
            if (sd_rd) rd_rises++;
        end
        if (sd_wr) wr_cycles++;
        if (sd_rd) rd_cycles++;
        if (loading) load_cycles++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy && !prev_busy) begin starts++; busy_rise_cyc = cyc; end
        if (bk_ena && !prev_ena) ena_rise_cyc = cyc;
        prev_req = sd_rd | sd_wr;
        prev_busy = busy;
        prev_ena = bk_ena;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_mon();
        req_rises = 0; wr_rises = 0; rd_rises = 0; wr_cycles = 0; rd_cycles = 0; load_cycles = 0;
        done_cnt = 0; err_cnt = 0; starts = 0; order_bad = 0; first_lba = 0; last_lba = 0;
    endtask

    task automatic enable(input bit ro);
        downloading = 1'b1;
        step(1);
        img_mounted = 1'b1; img_size_nz = 1'b1; img_readonly = ro;
        step(1);
        img_mounted = 1'b0; img_readonly = 1'b0; downloading = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done_cnt + err_cnt == 0 && n < budget) begin
            step(1);
            n++;
        end
        if (done_cnt + err_cnt == 0) check("wait_end_expired", 0, 1);
        step(1);
    endtask

    initial begin
        // Reset
        step(3);
        check("reset_outputs", int'({sd_lba, sd_rd, sd_wr, sect_idx, bk_ena, busy, loading, done, err}), 0);
        RESET_n = 1'b1;
        step(2);

        // Enable qualification
        enable(0);
        check("bk_ena_qualified", int'(bk_ena), 1);
        step(1);
        enable(1);
        check("bk_ena_readonly", int'(bk_ena), 0);
        step(1);
        enable(0);
        check("bk_ena_requalified", int'(bk_ena), 1);
        step(2);

        // Save slot 2, fixed 3-cycle ack pulses
        ack_mode = 3;
        clear_mon();
        slot = 2'd2; save_req = 1'b1;
        step(1);
        slot = 2'd0;
        wait_end(3000);
        check("save_wr_requests", wr_rises, 64);
        check("save_rd_cycles", rd_cycles, 0);
        check("save_first_lba", first_lba, 32'h80);
        check("save_last_lba", last_lba, 32'hBF);
        check("save_order", order_bad, 0);
        check("save_loading", load_cycles, 0);
        check("save_done", done_cnt, 1);
        check("save_err", err_cnt, 0);
        save_req = 1'b0;
        step(2);

        // Load slot 1, load and save rising together; mid-op save edge ignored
        ack_mode = 1;
        clear_mon();
        slot = 2'd1; load_req = 1'b1; save_req = 1'b1;
        step(20);
        save_req = 1'b0;
        step(3);
        save_req = 1'b1;
        wait_end(3000);
        step(20);
        check("load_first_lba", first_lba, 32'h40);
        check("load_rd_requests", rd_rises, 64);
        check("load_wr_cycles", wr_cycles, 0);
        check("load_done", done_cnt, 1);
        check("load_starts", starts, 1);
        load_req = 1'b0; save_req = 1'b0;
        step(2);

        // Timeout with ack never arriving
        ack_mode = 0;
        clear_mon();
        slot = 2'd0; save_req = 1'b1;
        wait_end(200);
        check("timeout_wr_cycles", wr_cycles, TIMEOUT);
        check("timeout_err", err_cnt, 1);
        check("timeout_done", done_cnt, 0);
        check("timeout_lba", int'(sd_lba), 0);
        check("timeout_busy", int'(busy), 0);
        save_req = 1'b0;
        step(2);

        // Reset mid-operation at sector 10
        ack_mode = 1;
        slot = 2'd3; load_req = 1'b1;
        begin
            int n = 0;
            while (!(busy && sect_idx == 6'd10) && n < 1000) begin step(1); n++; end
            check("reached_sector10", int'(sect_idx), 10);
        end
        RESET_n = 1'b0;
        step(1);
        check("midop_reset_outputs", int'({sd_lba, sd_rd, sd_wr, sect_idx, bk_ena, busy, loading, done, err}), 0);
        step(1);
        RESET_n = 1'b1; load_req = 1'b0;
        clear_mon();
        step(1);
        load_req = 1'b1;
        step(30);
        check("post_reset_no_start", starts, 0);

        // Held request: starts the cycle after bk_ena rises, no restart after done
        enable(0);
        wait_end(3000);
        check("held_start_latency", busy_rise_cyc - ena_rise_cyc, 1);
        step(100);
        check("held_single_start", starts, 1);
        check("held_done", done_cnt, 1);
        load_req = 1'b0;
        step(2);

        // Random traffic
        ack_mode = 2;
        enable(0);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) load_req = ~load_req;
            if ($urandom_range(0, 39) == 0) save_req = ~save_req;
            slot = SLOT_BITS'($urandom);
            if ($urandom_range(0, 299) == 0) downloading = ~downloading;
            img_mounted = downloading && ($urandom_range(0, 19) == 0);
            img_size_nz = ($urandom_range(0, 3) != 0);
            img_readonly = ($urandom_range(0, 3) == 0);
            RESET_n = ($urandom_range(0, 1999) != 0);
            step(1);
        end
        RESET_n = 1'b1;
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bk_sector_seq.md
Name: bk_sector_seq

Overview:
Sequences save-state load/save transfers between the on-chip state buffer (dual-port RAM) and the mounted backup image, one slot of 2^SECT_BITS 512-byte sectors per operation. It owns the backup-enable qualification, the sd_lba/sd_rd/sd_wr handshake with hps_io, and an ack timeout. It also generates the "loading" hold that the top level ORs into the system reset. It sits in the top-level emu between hps_io and the nvram dpram port B.

Parameters:
SLOT_BITS, 2, width of slot select; number of slots = 2^SLOT_BITS
SECT_BITS, 6, log2 of sectors per slot (64 sectors = 32 KB)
TIMEOUT, 50000000, clk_sys cycles allowed from request assertion to sd_ack rise

Ports:
clk_sys  in  1  system clock; all logic on rising edge
RESET_n  in  1  synchronous, active-low reset
downloading  in  1  ROM download in progress (ioctl_download)
img_mounted  in  1  image-mounted strobe from hps_io
img_size_nz  in  1  mounted image size non-zero
img_readonly  in  1  mounted image is read-only
load_req  in  1  load-state request level (menu status bit)
save_req  in  1  save-state request level (menu status bit)
slot  in  SLOT_BITS  slot select, sampled at operation start
sd_ack  in  1  hps_io sector transfer acknowledge
sd_lba  out  32  sector address
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
sect_idx  out  SECT_BITS  current sector within slot (= sd_lba[SECT_BITS-1:0])
bk_ena  out  1  backup image usable; gates requests and menu entries
busy  out  1  operation in progress
loading  out  1  load in progress; top level holds the system in reset
done  out  1  one-cycle pulse when the last sector completes
err  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (RESET_n=0 at a clock edge): all outputs 0, state IDLE, timeout counter 0, edge/ack history registers 0. Reset mid-operation aborts immediately: sd_rd/sd_wr drop on that edge, and no done/err pulse is issued.
- bk_ena: cleared on rising edge of downloading; set in any cycle where downloading & img_mounted & img_size_nz & ~img_readonly. If both occur in the same cycle, set wins. Changes to bk_ena during an operation do not affect that operation.
- Request qualification: q_load = load_req & bk_ena, q_save = save_req & bk_ena; previous values are registered every cycle. Start = rising edge of q_load or q_save. bk_ena rising while a request is held high therefore counts as an edge. Edges arriving while busy are consumed and ignored. If both edges arrive in the same cycle, load wins.
- States: IDLE, REQ, XFER.
- IDLE -> REQ on start, registered on the same edge:
  - sd_lba = {zero-extend, slot, SECT_BITS'b0}
  - loading = is_load
  - sd_rd = is_load; sd_wr = ~is_load
  - busy = 1; counter = 0
- REQ: counter increments each cycle.
  - On sd_ack rising edge (sd_ack & ~ack_d): clear sd_rd and sd_wr, go to XFER.
  - Otherwise, when counter reaches TIMEOUT-1: clear sd_rd, sd_wr, busy and loading, pulse err, go to IDLE. An ack already high on entry does not count; a fresh rise is required.
- XFER: wait for sd_ack falling edge.
  - If sect_idx is all ones: clear busy and loading, pulse done, go to IDLE.
  - Otherwise: sd_lba += 1 (wraps only within the low SECT_BITS field, never carries into the slot field); re-assert sd_rd = loading and sd_wr = ~loading; clear counter; go to REQ.
- sd_rd and sd_wr are never high together. The slot input is ignored after start.
- done and err are mutually exclusive and last exactly one cycle.

Test Plan:
- Enable: downloading 0->1, then one cycle with img_mounted=1, img_size_nz=1, img_readonly=0 -> bk_ena=1. Repeat with img_readonly=1 -> bk_ena stays 0 after the downloading edge.
- Save slot 2 (SLOT_BITS=2, SECT_BITS=6), ack pulsing 3 cycles high after each request -> sd_wr high for each of 64 sectors with sd_lba 0x80..0xBF in order, sd_rd never high, loading=0 throughout. done pulses once on the cycle after the 64th ack fall; busy 0 on that same edge.
- Load slot 1 with load_req and save_req rising in the same cycle -> sd_rd path only, sd_lba starts 0x40, loading=1 until done; a save_req edge mid-operation is ignored.
- Timeout (TIMEOUT=16), save request with sd_ack held 0 -> sd_wr high 16 cycles, then err pulses once, sd_wr=0, busy=0, sd_lba holds 0x00 (slot 0).
- Reset mid-operation: RESET_n low while sect_idx=10 -> all outputs 0, including bk_ena; a new load_req edge is ignored until bk_ena is re-qualified.
- Held request: load_req held high with bk_ena=0, then bk_ena set -> operation starts the cycle after bk_ena rises; load_req held high afterwards does not restart after done.
